// File: rtl/cuadrador_pkg.sv
// Shared types and helpers for the shift-and-add squarer and its optional accumulator.
// The accumulator helper is sized for the default operand width N_IN_DEF.
package cuadrador_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINALI = 2'd2
    } cuad_state_t;

    localparam int N_IN_DEF = 32;
    localparam int ACC_W    = 2 * N_IN_DEF;

    // Returns {carry_out, sum}; on carry-out the sum saturates to all ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ACC_W]) begin
            s = {1'b1, {ACC_W{1'b1}}};
        end
        return s;
    endfunction

endpackage

// File: rtl/cuadrador_acc.sv
// Saturating sum-of-squares accumulator with sticky overflow flag.
// Only instantiated when CUADRADOR_ACC_EN is defined.
module cuadrador_acc
    import cuadrador_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             add_en,
    input  logic [ACC_W-1:0] add_val,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    logic [ACC_W:0] sum;

    assign sum = sat_add(acc, add_val);

    // Clear and add are never requested on the same edge: clear is IDLE-only, add is CALC-only.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (add_en) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
        end
    end

endmodule

// File: rtl/cuadrador_32_64.sv
// Sequential unsigned squarer (RESULT = X*X), one shift-and-add partial product per cycle.
// Define CUADRADOR_ACC_EN to turn RESULT into a saturating running sum of squares.
module cuadrador_32_64
    import cuadrador_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [N_IN-1:0]   X,
    input  logic              ACC_CLR,
    output logic              FIN,
    output logic [2*N_IN-1:0] RESULT,
    output logic              OVF,
    output cuad_state_t       ESTADO
);

    // Handshake: START is a level request sampled only in IDLE; FIN is high for the whole
    // FINALI state and RESULT is valid then. FINALI is left only once START has dropped,
    // so each operation needs START low for at least one cycle before the next one.

    localparam int CW = $clog2(N_IN);

    cuad_state_t       state;
    logic [2*N_IN-1:0] p;
    logic [2*N_IN-1:0] m;
    logic [N_IN-1:0]   b;
    logic [CW-1:0]     cont;

    logic [2*N_IN-1:0] p_add;
    logic              last;
    logic              done;

    assign p_add = b[0] ? (p + m) : p;
    assign last  = (cont == CW'(N_IN - 1));
    assign done  = (state == CALC) && last;

    assign FIN    = (state == FINALI);
    assign ESTADO = state;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            p     <= '0;
            m     <= '0;
            b     <= '0;
            cont  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        m     <= {{N_IN{1'b0}}, X};
                        b     <= X;
                        p     <= '0;
                        cont  <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    p    <= p_add;
                    m    <= m << 1;
                    b    <= b >> 1;
                    cont <= cont + 1'b1;
                    if (last) begin
                        state <= FINALI;
                    end
                end
                FINALI: begin
                    if (!START) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CUADRADOR_ACC_EN
    // The accumulator register doubles as RESULT, so clearing it also clears RESULT.
    cuadrador_acc u_acc (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr     (ACC_CLR && (state == IDLE)),
        .add_en  (done),
        .add_val (p_add),
        .acc     (RESULT),
        .ovf     (OVF)
    );
`else
    logic [2*N_IN-1:0] result_q;
    logic              unused_acc_clr;

    assign unused_acc_clr = ACC_CLR;

    // The final add of the last CALC cycle is folded in so RESULT is ready on FINALI entry.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            result_q <= '0;
        end else if (done) begin
            result_q <= p_add;
        end
    end

    assign RESULT = result_q;
    assign OVF    = 1'b0;
`endif

endmodule

// File: tb/tb_cuadrador_32_64.sv
// Directed bench for cuadrador_32_64: vector table plus hold, reset and scramble sequences.
// Accumulator sequences are compiled in when CUADRADOR_ACC_EN is defined.
module tb_cuadrador_32_64;
    import cuadrador_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [31:0] X;
    logic        ACC_CLR;
    logic        FIN;
    logic [63:0] RESULT;
    logic        OVF;
    cuad_state_t ESTADO;

    int n_cmp = 0;
    int n_err = 0;

    cuadrador_32_64 dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .X       (X),
        .ACC_CLR (ACC_CLR),
        .FIN     (FIN),
        .RESULT  (RESULT),
        .OVF     (OVF),
        .ESTADO  (ESTADO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] x;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raises START with x at a falling edge, keeps it high until FIN, checks the
    // edge count (sampling edge included) and RESULT, then drops START.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [63:0] exp,
                          input bit scramble);
        int edges;
        edges = 0;
        @(negedge CLK);
        START = 1'b1;
        X     = x;
        while (edges < 45) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
            if (FIN) break;
            if (scramble) X = $urandom;
        end
        check({tag, " latency"}, 64'(edges), 64'd33);
        check({tag, " result"}, RESULT, exp);
        START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check({tag, " fin_drop"}, 64'(FIN), 64'd0);
        check({tag, " result_hold"}, RESULT, exp);
    endtask

    initial begin
        RESET   = 1'b0;
        START   = 1'b0;
        X       = '0;
        ACC_CLR = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset fin", 64'(FIN), 64'd0);
        check("reset result", RESULT, 64'd0);
        check("reset ovf", 64'(OVF), 64'd0);
        check("reset state", 64'(ESTADO), 64'(IDLE));
        RESET = 1'b1;

`ifndef CUADRADOR_ACC_EN
        vecs[0] = '{32'd0,          64'd0};
        vecs[1] = '{32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd46341,      64'd2147488281};
        vecs[3] = '{32'd3037000499, 64'd9223372030926249001};
        vecs[4] = '{32'd1,          64'd1};
        vecs[5] = '{32'h0001_0000,  64'h0000_0001_0000_0000};
        vecs[6] = '{32'h8000_0001,  64'h4000_0001_0000_0001};
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].exp, 1'b0);
        end

        // START held through FINALI: no restart, RESULT stable.
        @(negedge CLK);
        START = 1'b1;
        X     = 32'd5;
        for (int i = 0; i < 45 && !FIN; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("hold fin", 64'(FIN), 64'd1);
            check("hold result", RESULT, 64'd25);
        end
        START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("hold exit state", 64'(ESTADO), 64'(IDLE));
        run_op("after_hold", 32'd3, 64'd9, 1'b0);

        // Asynchronous reset in the middle of CALC.
        @(negedge CLK);
        START = 1'b1;
        X     = 32'd9;
        repeat (11) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("midreset fin", 64'(FIN), 64'd0);
        check("midreset result", RESULT, 64'd0);
        check("midreset state", 64'(ESTADO), 64'(IDLE));
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        run_op("post_reset", 32'd7, 64'd49, 1'b0);

        // Operand changes during CALC must not disturb the captured value.
        run_op("scramble", 32'd12345, 64'd152399025, 1'b1);
        run_op("scramble2", 32'hDEAD_BEEF, 64'hC1B1_CD12_216D_A321, 1'b1);
`else
        @(negedge CLK);
        ACC_CLR = 1'b1;
        @(negedge CLK);
        ACC_CLR = 1'b0;
        run_op("acc3", 32'd3, 64'd9, 1'b0);
        run_op("acc4", 32'd4, 64'd25, 1'b0);
        check("acc ovf0", 64'(OVF), 64'd0);
        run_op("accmax1", 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_001A, 1'b0);
        check("acc ovf1", 64'(OVF), 64'd0);
        run_op("accmax2", 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("acc ovf2", 64'(OVF), 64'd1);
        run_op("accmax3", 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("acc ovf sticky", 64'(OVF), 64'd1);
        @(negedge CLK);
        ACC_CLR = 1'b1;
        @(negedge CLK);
        ACC_CLR = 1'b0;
        check("acc clr result", RESULT, 64'd0);
        check("acc clr ovf", 64'(OVF), 64'd0);
        run_op("acc7", 32'd7, 64'd49, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
